spi_slave_core: RTL and testbench

SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

---
 rtl/spi_slave_core.sv | 190 +++++++++++++++++++
 tb/tb_spi_slave_core.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI slave core: synchronizes the master's sclk/ss/mosi into PCLK, shifts one byte
// per 8 sample edges, and exchanges bytes through a one-deep tx buffer and rx holding register.
module spi_slave_core (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       lsbfe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_rd,
  output logic       overrun,
  input  logic       ovr_clr,
  output logic       busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Synchronizer chains plus the registered copy used for edge detection.
  logic sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_prev_q, sclk_prev_d;
  logic ss_s1_q, ss_s1_d, ss_s2_q, ss_s2_d, ss_prev_q, ss_prev_d;
  logic mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_full_q, tx_full_d;

  logic       sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic       sample_edge, shift_edge, ss_fall, ss_rise;
  logic       byte_done, consume, ovr_set;
  logic [7:0] rx_next, tx_next, tx_reload;

  always_comb begin
    sclk_rise   = sclk_s2_q & ~sclk_prev_q;
    sclk_fall   = ~sclk_s2_q & sclk_prev_q;
    lead_edge   = cpol ? sclk_fall : sclk_rise;
    trail_edge  = cpol ? sclk_rise : sclk_fall;
    sample_edge = cpha ? trail_edge : lead_edge;
    shift_edge  = cpha ? lead_edge : trail_edge;
    ss_fall     = ~ss_s2_q & ss_prev_q;
    ss_rise     = ss_s2_q & ~ss_prev_q;
  end

  always_comb begin
    // NOTE: every _d is given a default before any branch so no latch can be inferred.
    sclk_s1_d   = sclk;
    sclk_s2_d   = sclk_s1_q;
    sclk_prev_d = sclk_s2_q;
    ss_s1_d     = ss;
    ss_s2_d     = ss_s1_q;
    ss_prev_d   = ss_s2_q;
    mosi_s1_d   = mosi;
    mosi_s2_d   = mosi_s1_q;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    byte_done  = 1'b0;
    consume    = 1'b0;
    ovr_set    = 1'b0;

    rx_next   = lsbfe ? {mosi_s2_q, rx_sh_q[7:1]} : {rx_sh_q[6:0], mosi_s2_q};
    tx_next   = lsbfe ? {1'b0, tx_sh_q[7:1]} : {tx_sh_q[6:0], 1'b0};
    tx_reload = tx_full_q ? tx_buf_q : 8'h00;

    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = 3'd0;
          rx_sh_d   = 8'h00;
          tx_sh_d   = tx_reload;
          consume   = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          rx_sh_d   = 8'h00;
          tx_sh_d   = 8'h00;
        end else if (sample_edge) begin
          rx_sh_d   = rx_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_done = 1'b1;
            consume   = 1'b1;
            tx_sh_d   = tx_reload;
          end
        end else if (shift_edge && bit_cnt_q != 3'd0) begin
          // A shift edge at count 0 is either the cpha=1 first edge or the edge right
          // after a reload; in both cases the freshly loaded first bit must stay on miso.
          tx_sh_d = tx_next;
        end
      end
      default: state_d = IDLE;
    endcase

    if (byte_done && (!rx_valid_q || rx_rd)) begin
      rx_data_d  = rx_next;
      rx_valid_d = 1'b1;
    end else begin
      ovr_set = byte_done;
      if (rx_rd) rx_valid_d = 1'b0;
    end

    if (ovr_set)      overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;

    if (consume) begin
      tx_full_d = 1'b0;
    end else if (tx_load && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    if (PRESET) begin
      sclk_s1_q   <= cpol;
      sclk_s2_q   <= cpol;
      sclk_prev_q <= cpol;
      ss_s1_q     <= 1'b1;
      ss_s2_q     <= 1'b1;
      ss_prev_q   <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      tx_sh_q     <= 8'h00;
      rx_sh_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      tx_buf_q    <= 8'h00;
      tx_full_q   <= 1'b0;
    end else begin
      sclk_s1_q   <= sclk_s1_d;
      sclk_s2_q   <= sclk_s2_d;
      sclk_prev_q <= sclk_prev_d;
      ss_s1_q     <= ss_s1_d;
      ss_s2_q     <= ss_s2_d;
      ss_prev_q   <= ss_prev_d;
      mosi_s1_q   <= mosi_s1_d;
      mosi_s2_q   <= mosi_s2_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
    end
  end

  assign busy     = (state_q == ACTIVE);
  assign miso_oe  = busy;
  assign miso     = busy & (lsbfe ? tx_sh_q[0] : tx_sh_q[7]);
  assign tx_ready = ~tx_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a bit-banged SPI master drives the slave while a byte-level
// model of the buffers and flags predicts every observed output.
module tb_spi_slave_core;

  localparam int H = 8;  // PCLK cycles per sclk half period

  logic       PCLK, PRESET, sclk, ss, mosi, miso, miso_oe;
  logic       cpol, cpha, lsbfe;
  logic [7:0] tx_data, rx_data;
  logic       tx_load, tx_ready, rx_valid, rx_rd, overrun, ovr_clr, busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Byte-level reference model.
  logic       m_rx_valid, m_overrun, m_tx_full;
  logic [7:0] m_rx_data, m_tx_buf, m_cur_tx;

  spi_slave_core dut (
    .PCLK(PCLK), .PRESET(PRESET), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd),
    .overrun(overrun), .ovr_clr(ovr_clr), .busy(busy)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic model_reset();
    m_rx_valid = 1'b0; m_overrun = 1'b0; m_tx_full = 1'b0;
    m_rx_data  = 8'h00; m_tx_buf = 8'h00; m_cur_tx = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESET = 1'b1; ss = 1'b1; sclk = cpol; mosi = 1'b0;
    wait_cyc(3);
    PRESET = 1'b0;
    model_reset();
    wait_cyc(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     busy,     1'b0);
    check({tag, "_miso"},     miso,     1'b0);
    check({tag, "_miso_oe"},  miso_oe,  1'b0);
    check({tag, "_rx_valid"}, rx_valid, 1'b0);
    check({tag, "_rx_data"},  rx_data,  8'h00);
    check({tag, "_overrun"},  overrun,  1'b0);
    check({tag, "_tx_ready"}, tx_ready, 1'b1);
  endtask

  task automatic set_mode(input logic cp, input logic ph, input logic lf);
    @(negedge PCLK);
    cpol = cp; cpha = ph; lsbfe = lf; sclk = cp;
    wait_cyc(6);
  endtask

  task automatic load(input logic [7:0] v);
    @(negedge PCLK);
    tx_data = v; tx_load = 1'b1;
    @(negedge PCLK);
    tx_load = 1'b0;
    if (!m_tx_full) begin
      m_tx_full = 1'b1;
      m_tx_buf  = v;
    end
    check("tx_ready_after_load", tx_ready, !m_tx_full);
  endtask

  task automatic rd_pulse();
    @(negedge PCLK);
    rx_rd = 1'b1;
    @(negedge PCLK);
    rx_rd = 1'b0;
    m_rx_valid = 1'b0;
    check("rx_valid_after_rd", rx_valid, 1'b0);
  endtask

  task automatic clr_pulse();
    @(negedge PCLK);
    ovr_clr = 1'b1;
    @(negedge PCLK);
    ovr_clr = 1'b0;
    m_overrun = 1'b0;
    check("overrun_after_clr", overrun, 1'b0);
  endtask

  task automatic ss_low();
    @(negedge PCLK);
    ss = 1'b0;
    m_cur_tx  = m_tx_full ? m_tx_buf : 8'h00;
    m_tx_full = 1'b0;
    wait_cyc(H);
    check("busy_active",     busy,     1'b1);
    check("miso_oe_active",  miso_oe,  1'b1);
    check("tx_ready_active", tx_ready, !m_tx_full);
  endtask

  task automatic ss_high();
    @(negedge PCLK);
    ss = 1'b1;
    wait_cyc(6);
    check("busy_idle",    busy,    1'b0);
    check("miso_oe_idle", miso_oe, 1'b0);
    check("miso_idle",    miso,    1'b0);
  endtask

  // After the 8th sample edge: model the completed byte and check its effects 4 PCLKs later.
  task automatic byte_complete(input logic [7:0] mtx);
    if (!m_rx_valid) begin
      m_rx_valid = 1'b1;
      m_rx_data  = mtx;
    end else begin
      m_overrun = 1'b1;
    end
    m_cur_tx  = m_tx_full ? m_tx_buf : 8'h00;
    m_tx_full = 1'b0;
    wait_cyc(4);
    check("rx_valid_latency", rx_valid, m_rx_valid);
    check("rx_data_byte",     rx_data,  m_rx_data);
    check("overrun_byte",     overrun,  m_overrun);
    check("tx_ready_byte",    tx_ready, !m_tx_full);
    wait_cyc(H - 4);
  endtask

  // Master side of one byte (or nbits of it); returns the bits captured from miso.
  task automatic spi_byte(input logic [7:0] mtx, input int nbits, output logic [7:0] got);
    logic [7:0] exp_tx;
    int idx;
    exp_tx = m_cur_tx;
    got    = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = lsbfe ? i : 7 - i;
      if (!cpha) begin
        mosi = mtx[idx];
        wait_cyc(H);
        got[idx] = miso;
        sclk = ~cpol;
        if (i == 7) byte_complete(mtx);
        else        wait_cyc(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mtx[idx];
        wait_cyc(H);
        got[idx] = miso;
        sclk = cpol;
        if (i == 7) byte_complete(mtx);
        else        wait_cyc(H);
      end
      check("miso_bit", got[idx], exp_tx[idx]);
    end
  endtask

  logic [7:0] got;
  logic [7:0] rnd_b;
  int         nbytes;

  initial begin
    PRESET = 1'b0; ss = 1'b1; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b1;
    sclk = 1'b0; tx_data = 8'h00; tx_load = 1'b0; rx_rd = 1'b0; ovr_clr = 1'b0;
    model_reset();
    do_reset();
    check_reset_outputs("reset");

    // Mode 0, LSB-first and MSB-first: tx 0xAA, rx 0xCC.
    for (int lf = 1; lf >= 0; lf--) begin
      set_mode(1'b0, 1'b0, lf[0]);
      load(8'hAA);
      ss_low();
      spi_byte(8'hCC, 8, got);
      ss_high();
      check("m0_master_rx", got, 8'hAA);
      check("m0_rx_data", rx_data, 8'hCC);
      check("m0_rx_valid", rx_valid, 1'b1);
      rd_pulse();
    end

    // Modes 1, 2, 3: tx 0x3C, rx 0x5A.
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0], 1'b0);
      load(8'h3C);
      ss_low();
      spi_byte(8'h5A, 8, got);
      ss_high();
      check("mode_master_rx", got, 8'h3C);
      check("mode_rx_data", rx_data, 8'h5A);
      rd_pulse();
    end

    // Back-to-back bytes without rx_rd; second load while full is ignored.
    set_mode(1'b0, 1'b0, 1'b1);
    load(8'h55);
    load(8'h66);
    ss_low();
    spi_byte(8'h11, 8, got);
    check("b2b_first_tx", got, 8'h55);
    spi_byte(8'h22, 8, got);
    check("b2b_second_tx_empty", got, 8'h00);
    ss_high();
    check("b2b_rx_data", rx_data, 8'h11);
    check("b2b_overrun", overrun, 1'b1);
    clr_pulse();
    rd_pulse();

    // No tx_load: miso all zero, tx_ready stays 1.
    ss_low();
    spi_byte(8'hE7, 8, got);
    ss_high();
    check("noload_master_rx", got, 8'h00);
    check("noload_tx_ready", tx_ready, 1'b1);
    rd_pulse();

    // Abort after 5 bits; a buffer loaded mid-transfer survives the abort.
    ss_low();
    load(8'h77);
    spi_byte(8'hB4, 5, got);
    ss_high();
    check("abort_rx_valid", rx_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_tx_ready", tx_ready, 1'b0);

    // Randomized transfers across modes against the model.
    for (int r = 0; r < 6; r++) begin
      set_mode($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) load(8'($urandom));
      nbytes = $urandom_range(1, 2);
      ss_low();
      for (int b = 0; b < nbytes; b++) begin
        rnd_b = 8'($urandom);
        spi_byte(rnd_b, 8, got);
      end
      ss_high();
      check("rand_rx_data", rx_data, m_rx_data);
      check("rand_overrun", overrun, m_overrun);
      if ($urandom_range(0, 1) == 1) rd_pulse();
      if (m_overrun) clr_pulse();
    end

    // Reset mid-transfer, then a clean transfer of 0x96.
    set_mode(1'b0, 1'b0, 1'b1);
    ss_low();
    spi_byte(8'hF0, 3, got);
    do_reset();
    check_reset_outputs("midreset");
    ss_low();
    spi_byte(8'h96, 8, got);
    ss_high();
    check("post_reset_rx_data", rx_data, 8'h96);
    check("post_reset_rx_valid", rx_valid, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
